// File: rtl/sub_pipe.sv
//------------------------------------------------------------------------------
// Module      : sub_pipe
// Description : Two-stage pipelined a - b - borrowIn subtractor, valid/ready.
//               Optional macro SUB_SAT_EN clamps d to 0 on unsigned borrow.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sub_pipe #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             inValid,
    output logic             inReady,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrowIn,
    output logic             outValid,
    input  logic             outReady,
    output logic [WIDTH-1:0] d,
    output logic             borrowOut,
    output logic             overflow
);

    localparam int c_LEVELS = $clog2(WIDTH);

    // Stage 1 state
    logic [WIDTH-1:0] r_g;
    logic [WIDTH-1:0] r_p;
    logic             r_cin;
    logic             r_aMsb;
    logic             r_bMsb;
    logic             r_s1Valid;

    // Stage 2 state
    logic [WIDTH-1:0] r_d;
    logic             r_borrowOut;
    logic             r_overflow;
    logic             r_s2Valid;

    logic             w_s2Free;
    logic             w_inAccept;
    logic [WIDTH-1:0] w_bn;
    logic [WIDTH-1:0] w_carry;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_dNext;
    logic             w_borrow;
    logic             w_overflow;

    assign w_s2Free   = !r_s2Valid || outReady;
    assign inReady    = !r_s1Valid || w_s2Free;
    assign w_inAccept = inValid && inReady;
    assign w_bn       = ~b;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_g       <= '0;
            r_p       <= '0;
            r_cin     <= 1'b0;
            r_aMsb    <= 1'b0;
            r_bMsb    <= 1'b0;
            r_s1Valid <= 1'b0;
        end else if (w_inAccept) begin
            r_g       <= a & w_bn;
            r_p       <= a ^ w_bn;
            r_cin     <= ~borrowIn;
            r_aMsb    <= a[WIDTH-1];
            r_bMsb    <= b[WIDTH-1];
            r_s1Valid <= 1'b1;
        end else if (w_s2Free) begin
            r_s1Valid <= 1'b0;
        end
    end

    // Kogge-Stone prefix over the stored g/p; cin folded into bit 0 so that
    // w_carry[i] is the carry out of bit i for the whole operation.
    always_comb begin
        logic [WIDTH-1:0] gCur;
        logic [WIDTH-1:0] pCur;
        logic [WIDTH-1:0] gNxt;
        logic [WIDTH-1:0] pNxt;
        gCur    = r_g;
        pCur    = r_p;
        gCur[0] = r_g[0] | (r_p[0] & r_cin);
        for (int lvl = 0; lvl < c_LEVELS; lvl++) begin
            gNxt = gCur;
            pNxt = pCur;
            for (int i = (1 << lvl); i < WIDTH; i++) begin
                gNxt[i] = gCur[i] | (pCur[i] & gCur[i - (1 << lvl)]);
                pNxt[i] = pCur[i] & pCur[i - (1 << lvl)];
            end
            gCur = gNxt;
            pCur = pNxt;
        end
        w_carry = gCur;
    end

    assign w_sum      = r_p ^ {w_carry[WIDTH-2:0], r_cin};
    assign w_borrow   = ~w_carry[WIDTH-1];
    assign w_overflow = (r_aMsb != r_bMsb) && (w_sum[WIDTH-1] != r_aMsb);

`ifdef SUB_SAT_EN
    assign w_dNext = w_borrow ? '0 : w_sum;
`else
    assign w_dNext = w_sum;
`endif

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_d         <= '0;
            r_borrowOut <= 1'b0;
            r_overflow  <= 1'b0;
            r_s2Valid   <= 1'b0;
        end else if (w_s2Free) begin
            r_s2Valid <= r_s1Valid;
            if (r_s1Valid) begin
                r_d         <= w_dNext;
                r_borrowOut <= w_borrow;
                r_overflow  <= w_overflow;
            end
        end
    end

    assign outValid  = r_s2Valid;
    assign d         = r_d;
    assign borrowOut = r_borrowOut;
    assign overflow  = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_sub_pipe.sv
//------------------------------------------------------------------------------
// Module      : tb_sub_pipe
// Description : Self-checking bench for sub_pipe against an arithmetic model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_sub_pipe;

    logic       clk = 1'b0;
    logic       rstN = 1'b0;
    logic       inValid = 1'b0;
    logic       inReady;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       borrowIn = 1'b0;
    logic       outValid;
    logic       outReady = 1'b0;
    logic [7:0] d;
    logic       borrowOut;
    logic       overflow;

    int nVec = 0;
    int nErr = 0;
    logic [9:0] expQ[$];

    sub_pipe #(.WIDTH(8)) dut (
        .clk(clk), .rstN(rstN), .inValid(inValid), .inReady(inReady),
        .a(a), .b(b), .borrowIn(borrowIn), .outValid(outValid),
        .outReady(outReady), .d(d), .borrowOut(borrowOut), .overflow(overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: {borrowOut, overflow, d} from plain integer arithmetic.
    function automatic logic [9:0] ref_sub(input logic [7:0] x, input logic [7:0] y, input logic bi);
        int ud;
        int sd;
        logic [7:0] dd;
        logic bo;
        logic ov;
        ud = int'(x) - int'(y) - int'(bi);
        sd = int'($signed(x)) - int'($signed(y)) - int'(bi);
        bo = (ud < 0);
        ov = (sd > 127) || (sd < -128);
        dd = ud[7:0];
`ifdef SUB_SAT_EN
        if (bo) dd = 8'h00;
`endif
        return {bo, ov, dd};
    endfunction

    // Applies inputs for one cycle and reports the handshakes of that cycle.
    task automatic drive_cycle(input bit vld, input logic [7:0] ia, input logic [7:0] ib,
                               input bit ibin, input bit ordy, output bit acc, output bit xfer);
        @(negedge clk);
        inValid  = vld;
        a        = ia;
        b        = ib;
        borrowIn = ibin;
        outReady = ordy;
        #1;
        acc  = inValid && inReady;
        xfer = outValid && outReady;
        if (acc) expQ.push_back(ref_sub(ia, ib, ibin));
    endtask

    task automatic test_reset();
        #1;
        nVec++;
        if ({outValid, d, borrowOut, overflow, inReady} !== {1'b0, 8'h00, 1'b0, 1'b0, 1'b1}) begin
            nErr++;
            $display("FAIL reset state: got v=%b d=%h bo=%b ov=%b rdy=%b want v=0 d=00 bo=0 ov=0 rdy=1",
                     outValid, d, borrowOut, overflow, inReady);
        end
        @(negedge clk);
        rstN = 1'b1;
        @(negedge clk);
        nVec++;
        if (outValid !== 1'b0) begin
            nErr++;
            $display("FAIL post-reset outValid: got %b want 0", outValid);
        end
    endtask

    task automatic test_directed();
        logic [16:0] vecs[4];
        logic [9:0] want;
        bit acc, xfer;
        vecs[0] = {8'h50, 8'h20, 1'b0};
        vecs[1] = {8'h00, 8'h01, 1'b0};
        vecs[2] = {8'h80, 8'h01, 1'b0};
        vecs[3] = {8'h10, 8'h0F, 1'b1};
        for (int i = 0; i < 4; i++) begin
            drive_cycle(1'b1, vecs[i][16:9], vecs[i][8:1], vecs[i][0], 1'b1, acc, xfer);
            drive_cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, acc, xfer);
            nVec++;
            if (outValid !== 1'b0) begin
                nErr++;
                $display("FAIL directed%0d early outValid: got %b want 0", i, outValid);
            end
            drive_cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, acc, xfer);
            nVec++;
            if (!xfer || expQ.size() == 0) begin
                nErr++;
                $display("FAIL directed%0d latency: outValid=%b want 1 after two cycles", i, outValid);
            end else begin
                want = expQ.pop_front();
                if ({borrowOut, overflow, d} !== want) begin
                    nErr++;
                    $display("FAIL directed%0d result: got bo=%b ov=%b d=%h want bo=%b ov=%b d=%h",
                             i, borrowOut, overflow, d, want[9], want[8], want[7:0]);
                end
            end
        end
        expQ.delete();
    endtask

    task automatic test_stream();
        logic [9:0] want;
        bit acc, xfer;
        int got = 0;
        for (int i = 0; i < 20; i++) begin
            if (i < 16) drive_cycle(1'b1, 8'($urandom), 8'($urandom), 1'($urandom), 1'b1, acc, xfer);
            else        drive_cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, acc, xfer);
            if (i < 16) begin
                nVec++;
                if (inReady !== 1'b1) begin
                    nErr++;
                    $display("FAIL stream inReady cycle %0d: got %b want 1", i, inReady);
                end
            end
            if (xfer) begin
                nVec++;
                if (expQ.size() == 0) begin
                    nErr++;
                    $display("FAIL stream extra result: got d=%h want none", d);
                end else begin
                    want = expQ.pop_front();
                    got++;
                    if ({borrowOut, overflow, d} !== want) begin
                        nErr++;
                        $display("FAIL stream result %0d: got bo=%b ov=%b d=%h want bo=%b ov=%b d=%h",
                                 got, borrowOut, overflow, d, want[9], want[8], want[7:0]);
                    end
                end
            end
        end
        nVec++;
        if (got != 16 || expQ.size() != 0) begin
            nErr++;
            $display("FAIL stream count: got %0d results want 16", got);
        end
        expQ.delete();
    endtask

    task automatic test_backpressure();
        logic [9:0] want;
        logic [7:0] held;
        bit acc, xfer;
        int accepts = 0;
        int got = 0;
        for (int i = 0; i < 5; i++) begin
            drive_cycle(1'b1, 8'($urandom), 8'($urandom), 1'($urandom), 1'b0, acc, xfer);
            if (acc) accepts++;
            if (i == 2) held = d;
            if (i >= 2) begin
                nVec++;
                if (inReady !== 1'b0 || outValid !== 1'b1 || d !== held) begin
                    nErr++;
                    $display("FAIL stall cycle %0d: got rdy=%b v=%b d=%h want rdy=0 v=1 d=%h",
                             i, inReady, outValid, d, held);
                end
            end
        end
        nVec++;
        if (accepts != 2) begin
            nErr++;
            $display("FAIL stall accepts: got %0d want 2", accepts);
        end
        for (int i = 0; i < 6; i++) begin
            drive_cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, acc, xfer);
            if (xfer) begin
                nVec++;
                if (expQ.size() == 0) begin
                    nErr++;
                    $display("FAIL drain duplicate: got d=%h want none", d);
                end else begin
                    want = expQ.pop_front();
                    got++;
                    if ({borrowOut, overflow, d} !== want) begin
                        nErr++;
                        $display("FAIL drain result %0d: got bo=%b ov=%b d=%h want bo=%b ov=%b d=%h",
                                 got, borrowOut, overflow, d, want[9], want[8], want[7:0]);
                    end
                end
            end
        end
        nVec++;
        if (got != 2) begin
            nErr++;
            $display("FAIL drain count: got %0d want 2", got);
        end
        expQ.delete();
    endtask

    task automatic test_reset_mid();
        logic [9:0] want;
        bit acc, xfer;
        drive_cycle(1'b1, 8'hA5, 8'h3C, 1'b0, 1'b0, acc, xfer);
        drive_cycle(1'b1, 8'h01, 8'h02, 1'b1, 1'b0, acc, xfer);
        @(negedge clk);
        inValid = 1'b0;
        #2 rstN = 1'b0;
        #1;
        nVec++;
        if (outValid !== 1'b0 || d !== 8'h00 || inReady !== 1'b1) begin
            nErr++;
            $display("FAIL mid reset: got v=%b d=%h rdy=%b want v=0 d=00 rdy=1", outValid, d, inReady);
        end
        expQ.delete();
        @(negedge clk);
        rstN = 1'b1;
        drive_cycle(1'b1, 8'h7F, 8'hFF, 1'b0, 1'b1, acc, xfer);
        nVec++;
        if (xfer) begin
            nErr++;
            $display("FAIL post reset transfer: got outValid=%b want 0", outValid);
        end
        drive_cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, acc, xfer);
        drive_cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, acc, xfer);
        nVec++;
        if (!xfer || expQ.size() == 0) begin
            nErr++;
            $display("FAIL post reset latency: got outValid=%b want 1", outValid);
        end else begin
            want = expQ.pop_front();
            if ({borrowOut, overflow, d} !== want) begin
                nErr++;
                $display("FAIL post reset result: got bo=%b ov=%b d=%h want bo=%b ov=%b d=%h",
                         borrowOut, overflow, d, want[9], want[8], want[7:0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_stream();
        test_backpressure();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule

`default_nettype wire
